// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state type, default width and high-time check for the clock ratio monitor
package clk_mon_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;
  // a high time is acceptable at either the floor or the ceiling of half the ratio
  function automatic logic hi_ok(input logic [31:0] hi, input logic [31:0] exp_r);
    return hi == (exp_r >> 1) || hi == ((exp_r + 32'd1) >> 1);
  endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: N-flop reset-to-zero synchronizer for asynchronous single-bit inputs
module bit_sync #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] ff;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ff <= '0;
    else ff <= {ff[N-2:0], i_d};
  assign o_q = ff[N-1];
endmodule

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures a divided clock in reference cycles and confirms the programmed ratio
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_mon_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_exp_ratio,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_err,
  output logic             o_timeout
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  state_t state_q, state_d;
  logic mon_sync, mon_prev, rise, fall, active, sat, good, done;
  logic valid_d, err_d, tmo_d, lock_d;
  logic [WIDTH-1:0] cnt, hi, exp_q;
  logic [3:0] match, match_d, match_inc;

  bit_sync #(.N(SYNC_STAGES)) u_sync (
    .i_clk  (i_ref_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_mon_clk),
    .o_q    (mon_sync)
  );

  assign rise      = mon_sync & ~mon_prev;
  assign fall      = ~mon_sync & mon_prev;
  assign active    = state_q == MEASURE || state_q == LOCKED;
  assign sat       = cnt == CNT_MAX;
  assign good      = cnt == exp_q && !sat && hi_ok(32'(hi), 32'(exp_q));
  assign match_inc = match + 4'd1;
  assign done      = good && match_inc == LOCK_N;

  // state register
  always_ff @(posedge i_ref_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;

  // next state: disable wins, a rise beats a simultaneous saturation
  always_comb begin
    state_d = state_q;
    if (!i_en) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = i_exp_ratio > WIDTH'(1) ? ARM : IDLE;
        ARM:     state_d = rise ? MEASURE : ARM;
        MEASURE: state_d = rise ? (done ? LOCKED : MEASURE) : sat ? ARM : MEASURE;
        LOCKED:  state_d = rise ? (good ? LOCKED : MEASURE) : sat ? ARM : LOCKED;
      endcase
  end

  // event pulses, lock flag and good-period run length for the coming cycle
  always_comb begin
    valid_d = i_en && active && rise;
    err_d   = valid_d && state_q == LOCKED && !good;
    tmo_d   = i_en && active && !rise && sat;
    lock_d  = (!i_en || err_d || tmo_d) ? 1'b0 : (valid_d && state_q == MEASURE && done) ? 1'b1 : o_lock;
    match_d = (!i_en || state_q == IDLE || tmo_d || (valid_d && !good)) ? 4'd0 :
              (valid_d && state_q == MEASURE) ? match_inc : match;
  end

  // period/high counters, captured ratio and registered outputs
  always_ff @(posedge i_ref_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      mon_prev  <= 1'b0;
      cnt       <= '0;
      hi        <= '0;
      exp_q     <= '0;
      match     <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_lock    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      mon_prev  <= mon_sync;
      cnt       <= !i_en ? '0 : state_q == IDLE ? cnt : rise ? WIDTH'(1) : sat ? cnt : cnt + WIDTH'(1);
      hi        <= !i_en ? '0 : (active && fall) ? cnt : hi;
      exp_q     <= (state_q == IDLE && state_d == ARM) ? i_exp_ratio : exp_q;
      match     <= match_d;
      o_period  <= !i_en ? '0 : valid_d ? cnt : o_period;
      o_high    <= !i_en ? '0 : valid_d ? hi : o_high;
      o_valid   <= valid_d;
      o_lock    <= lock_d;
      o_err     <= err_d;
      o_timeout <= tmo_d;
    end
endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: directed scoreboard bench for clk_ratio_monitor
module tb_clk_ratio_monitor;
  typedef struct packed {
    logic [7:0] period;
    logic [7:0] high;
    logic       lock;
    logic       err;
  } exp_t;

  logic ref_clk = 1'b0, rst_n = 1'b0, mon_clk = 1'b0, en = 1'b0;
  logic [7:0] exp_ratio = 8'd4;
  logic [7:0] period, high;
  logic valid, lock, err, timeout;
  int checks = 0, failures = 0;
  exp_t q[$];
  int div = 4, hi_cyc = 2, pend_div = 4, pend_hi = 2, ph = 0;
  bit run = 1'b1;

  clk_ratio_monitor #(.WIDTH(8), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
    .i_ref_clk  (ref_clk),
    .i_rst_n    (rst_n),
    .i_mon_clk  (mon_clk),
    .i_en       (en),
    .i_exp_ratio(exp_ratio),
    .o_period   (period),
    .o_high     (high),
    .o_valid    (valid),
    .o_lock     (lock),
    .o_err      (err),
    .o_timeout  (timeout)
  );

  always #5 ref_clk = ~ref_clk;

  // phase-locked divider model; ratio/high changes take effect on a rising edge
  always @(negedge ref_clk) begin
    if (!run) begin
      mon_clk = 1'b0;
      ph = 0;
    end else begin
      if (ph == 0) begin
        div = pend_div;
        hi_cyc = pend_hi;
      end
      mon_clk = ph < hi_cyc;
      ph = (ph + 1 >= div) ? 0 : ph + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every valid seen while expectations are queued is compared in order
  always @(negedge ref_clk) if (valid && q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    chk("period", period, e.period);
    chk("high", high, e.high);
    chk("lock", lock, e.lock);
    chk("err", err, e.err);
  end

  task automatic push(input int n, input logic [7:0] p, input logic [7:0] h, input int lock_at);
    for (int i = 1; i <= n; i++)
      q.push_back(exp_t'{period: p, high: h, lock: (lock_at != 0 && i >= lock_at), err: 1'b0});
  endtask

  task automatic start(input logic [7:0] r, input int n, input logic [7:0] p, input logic [7:0] h, input int lock_at);
    @(negedge ref_clk);
    en = 1'b0;
    @(negedge ref_clk);
    push(n, p, h, lock_at);
    exp_ratio = r;
    en = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge ref_clk);
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge ref_clk);
      n++;
    end while (!valid && n < 100);
    chk("wait_valid", valid, 1);
  endtask

  initial begin
    repeat (3) @(negedge ref_clk);
    chk("rst_period", period, 0);
    chk("rst_high", high, 0);
    chk("rst_flags", {valid, lock, err, timeout}, 0);
    rst_n = 1'b1;
    start(8'd4, 4, 8'd4, 8'd2, 4);
    drain("lock4_drain");
    chk("lock4_held", lock, 1);
    wait_valid();
    @(posedge ref_clk);
    pend_div = 8;
    pend_hi = 4;
    q.push_back(exp_t'{period: 8'd4, high: 8'd2, lock: 1'b1, err: 1'b0});
    q.push_back(exp_t'{period: 8'd8, high: 8'd4, lock: 1'b0, err: 1'b1});
    push(3, 8'd8, 8'd4, 0);
    drain("reconf_drain");
    chk("reconf_unlocked", lock, 0);
    @(negedge ref_clk);
    en = 1'b0;
    @(negedge ref_clk);
    chk("dis_period", period, 0);
    chk("dis_high", high, 0);
    chk("dis_lock", lock, 0);
    pend_div = 5;
    pend_hi = 2;
    repeat (20) @(negedge ref_clk);
    start(8'd5, 4, 8'd5, 8'd2, 4);
    drain("r5h2_drain");
    pend_hi = 3;
    repeat (20) @(negedge ref_clk);
    start(8'd5, 4, 8'd5, 8'd3, 4);
    drain("r5h3_drain");
    chk("r5_lock", lock, 1);
    pend_div = 4;
    pend_hi = 2;
    repeat (20) @(negedge ref_clk);
    start(8'd6, 6, 8'd4, 8'd2, 0);
    drain("mis_drain");
    chk("mis_lock", lock, 0);
    start(8'd4, 4, 8'd4, 8'd2, 4);
    drain("tmo_lock_drain");
    wait_valid();
    @(posedge ref_clk);
    run = 1'b0;
    repeat (254) @(negedge ref_clk);
    chk("tmo_early", timeout, 0);
    @(negedge ref_clk);
    chk("tmo_pulse", timeout, 1);
    chk("tmo_lock", lock, 0);
    @(negedge ref_clk);
    chk("tmo_once", timeout, 0);
    push(4, 8'd4, 8'd2, 4);
    run = 1'b1;
    drain("resume_drain");
    chk("resume_lock", lock, 1);
    @(negedge ref_clk);
    en = 1'b0;
    @(negedge ref_clk);
    exp_ratio = 8'd1;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge ref_clk);
      chk("bypass", {period, high, valid, lock, err, timeout}, 0);
    end
    start(8'd4, 2, 8'd4, 8'd2, 0);
    drain("pre_rst_drain");
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {period, high, valid, lock, err, timeout}, 0);
    repeat (3) @(negedge ref_clk);
    push(4, 8'd4, 8'd2, 4);
    rst_n = 1'b1;
    drain("relock_drain");
    chk("relock", lock, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end
endmodule
